// File: rtl/bank_sram_ctrl_if.sv
// Issue-queue -> SRAM-controller command channel.
// The issue queue drives the command (master); the controller answers with
// ready (slave). A command transfers on a cycle where valid & ready.
//   iq_sc_valid_i                    : command valid
//   iq_sc_ready_o                    : controller idle, command accepted
//   iq_sc_opcode_i                   : 0 write, 1 read, 2 linefill, 3 write back
//   iq_sc_channel_id_i               : requesting channel
//   iq_sc_xbar_rob_num_i             : requester ROB id
//   iq_sc_set_way_offset_i           : SRAM entry address
//   iq_sc_wbuffer_id_i               : write-buffer entry (write only)
//   iq_sc_cacheline_state_offset0/1_i: half-line states, 2'b11 = dirty
interface bank_sram_ctrl_if;
  logic       iq_sc_valid_i;
  logic       iq_sc_ready_o;
  logic [2:0] iq_sc_opcode_i;
  logic [1:0] iq_sc_channel_id_i;
  logic [2:0] iq_sc_xbar_rob_num_i;
  logic [6:0] iq_sc_set_way_offset_i;
  logic [7:0] iq_sc_wbuffer_id_i;
  logic [1:0] iq_sc_cacheline_state_offset0_i;
  logic [1:0] iq_sc_cacheline_state_offset1_i;

  modport master (
    output iq_sc_valid_i, iq_sc_opcode_i, iq_sc_channel_id_i, iq_sc_xbar_rob_num_i,
           iq_sc_set_way_offset_i, iq_sc_wbuffer_id_i,
           iq_sc_cacheline_state_offset0_i, iq_sc_cacheline_state_offset1_i,
    input  iq_sc_ready_o
  );

  modport slave (
    input  iq_sc_valid_i, iq_sc_opcode_i, iq_sc_channel_id_i, iq_sc_xbar_rob_num_i,
           iq_sc_set_way_offset_i, iq_sc_wbuffer_id_i,
           iq_sc_cacheline_state_offset0_i, iq_sc_cacheline_state_offset1_i,
    output iq_sc_ready_o
  );
endinterface

// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller. Executes one issue-queue command at a time against
// the bank data SRAM: write from write buffer, read, read with BIU linefill,
// and write back to the BIU.
//   clk_i, rst_i (async, active-low)
//   iq               : command channel (slave side)
//   sram_*           : single-port SRAM, read data one cycle after en & ~wen
//   wbuf_*           : write-buffer read port, data one cycle after ren
//   biu_sc_r*        : linefill beat from BIU (no backpressure)
//   sc_biu_w*        : write-back beat to BIU (valid/ready)
//   sc_resp_*        : one-cycle response pulse to the requesting channel
//   sc_err_o         : sticky, reserved opcode was accepted
// All outputs are decoded from the state register and latched command, so
// they never depend combinationally on any input.
module bank_sram_ctrl #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  bank_sram_ctrl_if.slave       iq,
  output logic                  sram_en_o,
  output logic                  sram_wen_o,
  output logic [6:0]            sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  wbuf_ren_o,
  output logic [7:0]            wbuf_rid_o,
  input  logic [DATA_WIDTH-1:0] wbuf_rdata_i,
  input  logic                  biu_sc_rvalid_i,
  input  logic [DATA_WIDTH-1:0] biu_sc_rdata_i,
  output logic                  sc_biu_wvalid_o,
  input  logic                  sc_biu_wready_i,
  output logic [DATA_WIDTH-1:0] sc_biu_wdata_o,
  output logic [1:0]            sc_biu_wmask_o,
  output logic                  sc_resp_valid_o,
  output logic [1:0]            sc_resp_ch_id_o,
  output logic [2:0]            sc_resp_rob_num_o,
  output logic [DATA_WIDTH-1:0] sc_resp_data_o,
  output logic                  sc_err_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_BUF   = 4'd1,
    S_WR_WAIT  = 4'd2,
    S_WR_SRAM  = 4'd3,
    S_RD_SRAM  = 4'd4,
    S_RD_WAIT  = 4'd5,
    S_RD_RESP  = 4'd6,
    S_LF_WAIT  = 4'd7,
    S_LF_WRITE = 4'd8,
    S_WB_READ  = 4'd9,
    S_WB_WAIT  = 4'd10,
    S_WB_SEND  = 4'd11
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_accept;
  logic                  w_err_set;
  logic                  w_data_ld;
  logic [DATA_WIDTH-1:0] w_data_nxt;

  logic [1:0]            r_ch;
  logic [2:0]            r_rob;
  logic [6:0]            r_addr;
  logic [7:0]            r_wbuf_id;
  logic [1:0]            r_st0;
  logic [1:0]            r_st1;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  r_err;

  assign iq.iq_sc_ready_o = (r_state == S_IDLE);
  assign sc_err_o         = r_err;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, command accept and data-holding-register load selection.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    w_data_ld   = 1'b0;
    w_data_nxt  = r_data_q;
    case (r_state)
      S_IDLE: begin
        if (iq.iq_sc_valid_i) begin
          // Reserved opcodes only flag the error; the command register is
          // left untouched so nothing else observable changes.
          case (iq.iq_sc_opcode_i)
            3'd0:    begin w_state_nxt = S_WR_BUF;  w_accept = 1'b1; end
            3'd1:    begin w_state_nxt = S_RD_SRAM; w_accept = 1'b1; end
            3'd2:    begin w_state_nxt = S_LF_WAIT; w_accept = 1'b1; end
            3'd3:    begin w_state_nxt = S_WB_READ; w_accept = 1'b1; end
            default: begin w_err_set = 1'b1; end
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_BUF:  w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        w_state_nxt = S_WR_SRAM;
        w_data_ld   = 1'b1;
        w_data_nxt  = wbuf_rdata_i;
      end
      S_WR_SRAM: w_state_nxt = S_IDLE;
      S_RD_SRAM: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        w_state_nxt = S_RD_RESP;
        w_data_ld   = 1'b1;
        w_data_nxt  = sram_rdata_i;
      end
      S_RD_RESP: w_state_nxt = S_IDLE;
      S_LF_WAIT: begin
        if (biu_sc_rvalid_i) begin
          w_state_nxt = S_LF_WRITE;
          w_data_ld   = 1'b1;
          w_data_nxt  = biu_sc_rdata_i;
        end else begin
          w_state_nxt = S_LF_WAIT;
        end
      end
      S_LF_WRITE: w_state_nxt = S_IDLE;
      S_WB_READ:  w_state_nxt = S_WB_WAIT;
      S_WB_WAIT: begin
        w_state_nxt = S_WB_SEND;
        w_data_ld   = 1'b1;
        w_data_nxt  = sram_rdata_i;
      end
      S_WB_SEND: begin
        if (sc_biu_wready_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WB_SEND;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command register, captured on accept of a valid opcode.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ch      <= 2'd0;
      r_rob     <= 3'd0;
      r_addr    <= 7'd0;
      r_wbuf_id <= 8'd0;
      r_st0     <= 2'd0;
      r_st1     <= 2'd0;
    end else if (w_accept) begin
      r_ch      <= iq.iq_sc_channel_id_i;
      r_rob     <= iq.iq_sc_xbar_rob_num_i;
      r_addr    <= iq.iq_sc_set_way_offset_i;
      r_wbuf_id <= iq.iq_sc_wbuffer_id_i;
      r_st0     <= iq.iq_sc_cacheline_state_offset0_i;
      r_st1     <= iq.iq_sc_cacheline_state_offset1_i;
    end
  end

  // Single data holding register shared by all command types.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_data_q <= '0;
    end else if (w_data_ld) begin
      r_data_q <= w_data_nxt;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  // Output decode; every field is forced to zero when its qualifier is low.
  always_comb begin
    sram_en_o         = 1'b0;
    sram_wen_o        = 1'b0;
    sram_addr_o       = 7'd0;
    sram_wdata_o      = '0;
    wbuf_ren_o        = 1'b0;
    wbuf_rid_o        = 8'd0;
    sc_biu_wvalid_o   = 1'b0;
    sc_biu_wdata_o    = '0;
    sc_biu_wmask_o    = 2'b00;
    sc_resp_valid_o   = 1'b0;
    sc_resp_ch_id_o   = 2'd0;
    sc_resp_rob_num_o = 3'd0;
    sc_resp_data_o    = '0;
    case (r_state)
      S_WR_BUF: begin
        wbuf_ren_o = 1'b1;
        wbuf_rid_o = r_wbuf_id;
      end
      S_WR_SRAM: begin
        sram_en_o    = 1'b1;
        sram_wen_o   = 1'b1;
        sram_addr_o  = r_addr;
        sram_wdata_o = r_data_q;
      end
      S_RD_SRAM, S_WB_READ: begin
        sram_en_o   = 1'b1;
        sram_addr_o = r_addr;
      end
      S_RD_RESP: begin
        sc_resp_valid_o   = 1'b1;
        sc_resp_ch_id_o   = r_ch;
        sc_resp_rob_num_o = r_rob;
        sc_resp_data_o    = r_data_q;
      end
      S_LF_WRITE: begin
        sram_en_o         = 1'b1;
        sram_wen_o        = 1'b1;
        sram_addr_o       = r_addr;
        sram_wdata_o      = r_data_q;
        sc_resp_valid_o   = 1'b1;
        sc_resp_ch_id_o   = r_ch;
        sc_resp_rob_num_o = r_rob;
        sc_resp_data_o    = r_data_q;
      end
      S_WB_SEND: begin
        sc_biu_wvalid_o = 1'b1;
        sc_biu_wdata_o  = r_data_q;
        sc_biu_wmask_o  = {(r_st1 == 2'b11), (r_st0 == 2'b11)};
      end
      default: begin
        sram_en_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bank_sram_ctrl.sv
// Scoreboard bench for bank_sram_ctrl: stimulus pushes hand-computed expected
// events (kind, cycle, fields) into a queue; a negedge monitor pops and
// compares each SRAM access, write-buffer read, response and BIU beat.
module tb_bank_sram_ctrl;
  localparam int DW = 128;
  localparam int K_WBUF = 0, K_SWR = 1, K_SRD = 2, K_RESP = 3, K_BIU = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bank_sram_ctrl_if u_if ();

  logic          sram_en, sram_wen, wbuf_ren, biu_rvalid, biu_wvalid, biu_wready;
  logic          resp_valid, err;
  logic [6:0]    sram_addr;
  logic [7:0]    wbuf_rid;
  logic [1:0]    biu_wmask, resp_ch;
  logic [2:0]    resp_rob;
  logic [DW-1:0] sram_wdata, sram_rdata, wbuf_rdata, biu_rdata, biu_wdata, resp_data;
  logic [DW-1:0] wbuf_val;
  logic [DW-1:0] mem [128];

  bank_sram_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_n), .iq(u_if),
    .sram_en_o(sram_en), .sram_wen_o(sram_wen), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .wbuf_ren_o(wbuf_ren), .wbuf_rid_o(wbuf_rid), .wbuf_rdata_i(wbuf_rdata),
    .biu_sc_rvalid_i(biu_rvalid), .biu_sc_rdata_i(biu_rdata),
    .sc_biu_wvalid_o(biu_wvalid), .sc_biu_wready_i(biu_wready),
    .sc_biu_wdata_o(biu_wdata), .sc_biu_wmask_o(biu_wmask),
    .sc_resp_valid_o(resp_valid), .sc_resp_ch_id_o(resp_ch),
    .sc_resp_rob_num_o(resp_rob), .sc_resp_data_o(resp_data),
    .sc_err_o(err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM and write-buffer stubs with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en && sram_wen) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_wen) sram_rdata <= mem[sram_addr];
    wbuf_rdata <= wbuf_ren ? wbuf_val : '0;
  end

  typedef struct {
    int            kind;
    int            cyc;
    logic [7:0]    a;
    logic [2:0]    b;
    logic [DW-1:0] d;
  } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic push(input int kind, input int c, input logic [7:0] a,
                      input logic [2:0] b, input logic [DW-1:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [7:0] a,
                          input logic [2:0] b, input logic [DW-1:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d a=%h b=%h d=%h, required none",
               kind, cyc, a, b, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b || e.d != d) begin
        n_err++;
        $display("FAIL event: got kind=%0d cyc=%0d a=%h b=%h d=%h, required kind=%0d cyc=%0d a=%h b=%h d=%h",
                 kind, cyc, a, b, d, e.kind, e.cyc, e.a, e.b, e.d);
      end
    end
  endtask

  // Monitor: fixed order within a cycle (wbuf, sram, resp, biu).
  always @(negedge clk) begin
    if (wbuf_ren) check_ev(K_WBUF, wbuf_rid, 3'd0, '0);
    if (sram_en && sram_wen) check_ev(K_SWR, {1'b0, sram_addr}, 3'd0, sram_wdata);
    if (sram_en && !sram_wen) check_ev(K_SRD, {1'b0, sram_addr}, 3'd0, '0);
    if (resp_valid) check_ev(K_RESP, {6'd0, resp_ch}, resp_rob, resp_data);
    if (biu_wvalid && biu_wready) check_ev(K_BIU, 8'd0, {1'b0, biu_wmask}, biu_wdata);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [2:0] rob,
                       input logic [6:0] addr, input logic [7:0] wid,
                       input logic [1:0] s0, input logic [1:0] s1);
    u_if.iq_sc_valid_i                   = 1'b1;
    u_if.iq_sc_opcode_i                  = op;
    u_if.iq_sc_channel_id_i              = ch;
    u_if.iq_sc_xbar_rob_num_i            = rob;
    u_if.iq_sc_set_way_offset_i          = addr;
    u_if.iq_sc_wbuffer_id_i              = wid;
    u_if.iq_sc_cacheline_state_offset0_i = s0;
    u_if.iq_sc_cacheline_state_offset1_i = s1;
    tick();
    u_if.iq_sc_valid_i = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int req_cyc);
    int n;
    n = 0;
    while (!u_if.iq_sc_ready_o && n < 40) begin
      tick();
      n++;
    end
    if (!u_if.iq_sc_ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: ready timeout at cyc %0d, required ready at cyc %0d", name, cyc, req_cyc);
    end else begin
      chk(name, DW'(cyc), DW'(req_cyc));
    end
  endtask

  function automatic logic outs_nonzero();
    return |{sram_en, sram_wen, sram_addr, sram_wdata, wbuf_ren, wbuf_rid, biu_wvalid,
             biu_wdata, biu_wmask, resp_valid, resp_ch, resp_rob, resp_data};
  endfunction

  int t;
  logic [DW-1:0] aa;

  initial begin
    aa = {16{8'hAA}};
    rst_n = 1'b0;
    u_if.iq_sc_valid_i = 1'b0;
    u_if.iq_sc_opcode_i = 3'd0;
    u_if.iq_sc_channel_id_i = 2'd0;
    u_if.iq_sc_xbar_rob_num_i = 3'd0;
    u_if.iq_sc_set_way_offset_i = 7'd0;
    u_if.iq_sc_wbuffer_id_i = 8'd0;
    u_if.iq_sc_cacheline_state_offset0_i = 2'd0;
    u_if.iq_sc_cacheline_state_offset1_i = 2'd0;
    biu_rvalid = 1'b0; biu_rdata = '0; biu_wready = 1'b0; wbuf_val = '0;
    repeat (3) tick();
    chk("rst_ready", DW'(u_if.iq_sc_ready_o), DW'(1'b1));
    chk("rst_err", DW'(err), DW'(1'b0));
    chk("rst_outs_zero", DW'(outs_nonzero()), DW'(1'b0));
    rst_n = 1'b1;
    tick();

    // Stray BIU beat while idle: ignored.
    biu_rvalid = 1'b1; biu_rdata = DW'(128'hDEAD);
    tick();
    biu_rvalid = 1'b0;
    chk("stray_beat_ready", DW'(u_if.iq_sc_ready_o), DW'(1'b1));

    // Write from write buffer.
    wbuf_val = aa;
    t = cyc;
    push(K_WBUF, t + 1, 8'h3A, 3'd0, '0);
    push(K_SWR, t + 3, 8'h15, 3'd0, aa);
    issue(3'd0, 2'd1, 3'd1, 7'h15, 8'h3A, 2'd0, 2'd0);
    wait_ready("wr_ready", t + 4);

    // Read back.
    t = cyc;
    push(K_SRD, t + 1, 8'h15, 3'd0, '0);
    push(K_RESP, t + 3, 8'd2, 3'd5, aa);
    issue(3'd1, 2'd2, 3'd5, 7'h15, 8'h00, 2'd0, 2'd0);
    wait_ready("rd_ready", t + 4);

    // Linefill, beat 10 cycles after accept.
    t = cyc;
    issue(3'd2, 2'd1, 3'd3, 7'h40, 8'h00, 2'd0, 2'd0);
    while (cyc < t + 10) begin
      chk("lf_ready_low", DW'(u_if.iq_sc_ready_o), DW'(1'b0));
      tick();
    end
    push(K_SWR, t + 11, 8'h40, 3'd0, DW'(128'h1234));
    push(K_RESP, t + 11, 8'd1, 3'd3, DW'(128'h1234));
    biu_rvalid = 1'b1; biu_rdata = DW'(128'h1234);
    tick();
    biu_rvalid = 1'b0;
    wait_ready("lf_ready", t + 12);

    // Back-to-back read of the linefilled entry.
    t = cyc;
    push(K_SRD, t + 1, 8'h40, 3'd0, '0);
    push(K_RESP, t + 3, 8'd3, 3'd7, DW'(128'h1234));
    issue(3'd1, 2'd3, 3'd7, 7'h40, 8'h00, 2'd0, 2'd0);
    wait_ready("b2b_ready", t + 4);

    // Linefill with beat at T+1.
    t = cyc;
    push(K_SWR, t + 2, 8'h41, 3'd0, DW'(128'h5678));
    push(K_RESP, t + 2, 8'd0, 3'd1, DW'(128'h5678));
    issue(3'd2, 2'd0, 3'd1, 7'h41, 8'h00, 2'd0, 2'd0);
    biu_rvalid = 1'b1; biu_rdata = DW'(128'h5678);
    tick();
    biu_rvalid = 1'b0;
    wait_ready("lf_fast_ready", t + 3);

    // Write back, offset1 dirty, wready low for 5 WB_SEND cycles.
    t = cyc;
    push(K_SRD, t + 1, 8'h40, 3'd0, '0);
    push(K_BIU, t + 8, 8'd0, 3'b010, DW'(128'h1234));
    issue(3'd3, 2'd0, 3'd0, 7'h40, 8'h00, 2'b00, 2'b11);
    while (cyc < t + 8) begin
      if (cyc >= t + 3) begin
        chk("wb_wvalid_hold", DW'(biu_wvalid), DW'(1'b1));
        chk("wb_wdata_hold", biu_wdata, DW'(128'h1234));
      end
      tick();
    end
    biu_wready = 1'b1;
    tick();
    biu_wready = 1'b0;
    wait_ready("wb_ready", t + 9);

    // Write back with clean mask still sends the beat.
    biu_wready = 1'b1;
    t = cyc;
    push(K_SRD, t + 1, 8'h15, 3'd0, '0);
    push(K_BIU, t + 3, 8'd0, 3'b000, aa);
    issue(3'd3, 2'd0, 3'd0, 7'h15, 8'h00, 2'b00, 2'b00);
    wait_ready("wb_clean_ready", t + 4);
    biu_wready = 1'b0;

    // Reserved opcode.
    issue(3'd5, 2'd1, 3'd2, 7'h22, 8'h11, 2'b11, 2'b11);
    chk("rsv_err", DW'(err), DW'(1'b1));
    chk("rsv_ready", DW'(u_if.iq_sc_ready_o), DW'(1'b1));
    repeat (3) tick();
    chk("rsv_err_sticky", DW'(err), DW'(1'b1));

    // Reset during LF_WAIT, then a late beat must be ignored.
    issue(3'd2, 2'd1, 3'd6, 7'h50, 8'h00, 2'd0, 2'd0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", DW'(u_if.iq_sc_ready_o), DW'(1'b1));
    chk("mid_rst_err", DW'(err), DW'(1'b0));
    chk("mid_rst_outs_zero", DW'(outs_nonzero()), DW'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    biu_rvalid = 1'b1; biu_rdata = DW'(128'h9999);
    tick();
    biu_rvalid = 1'b0;
    repeat (2) tick();

    // Normal read after the aborted command.
    t = cyc;
    push(K_SRD, t + 1, 8'h41, 3'd0, '0);
    push(K_RESP, t + 3, 8'd2, 3'd4, DW'(128'h5678));
    issue(3'd1, 2'd2, 3'd4, 7'h41, 8'h00, 2'd0, 2'd0);
    wait_ready("post_rst_ready", t + 4);

    repeat (5) tick();
    chk("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
